// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: forwarding select codes, T_new classes,
// the scoreboard entry layout and small entry helpers.
package hazard_pkg;

    localparam int SB_REG_W = 5;
    localparam int SB_T_W   = 2;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    localparam logic [SB_T_W-1:0] T_NEW_ALU  = 2'd1;
    localparam logic [SB_T_W-1:0] T_NEW_LOAD = 2'd2;
    localparam logic [SB_T_W-1:0] T_NEW_LINK = 2'd0;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] a3;
        logic [SB_T_W-1:0]   tnew;
    } sb_entry_t;

    // tnew counts down one per stage and parks at zero instead of wrapping.
    function automatic logic [SB_T_W-1:0] tnewDec(input logic [SB_T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic isWriter(input sb_entry_t e);
        return e.valid && (e.a3 != '0);
    endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand hazard check: finds the nearest writer of one register among
// E, M and W and decides between stalling, forwarding or reading the GRF.
module hazard_operand_check
    import hazard_pkg::*;
(
    input  logic [SB_REG_W-1:0] i_idx,
    input  logic [SB_T_W-1:0]   i_tUse,
    input  sb_entry_t           i_entE,
    input  sb_entry_t           i_entM,
    input  sb_entry_t           i_entW,
    output logic                o_stallReq,
    output logic [1:0]          o_fwdSel
);

    logic w_hitE;
    logic w_hitM;
    logic w_hitW;

    assign w_hitE = isWriter(i_entE) && (i_entE.a3 == i_idx);
    assign w_hitM = isWriter(i_entM) && (i_entM.a3 == i_idx);
    assign w_hitW = isWriter(i_entW) && (i_entW.a3 == i_idx);

    // The nearest matching stage decides alone; a not-yet-ready nearer writer
    // hides any older copy so a stale value is never forwarded.
    always_comb begin
        o_stallReq = 1'b0;
        o_fwdSel   = FWD_NONE;
        if (i_idx != '0) begin
            if (w_hitE) begin
                o_stallReq = i_entE.tnew > i_tUse;
                if (i_entE.tnew == '0) o_fwdSel = FWD_E;
            end else if (w_hitM) begin
                o_stallReq = i_entM.tnew > i_tUse;
                if (i_entM.tnew == '0) o_fwdSel = FWD_M;
            end else if (w_hitW && (i_entW.tnew == '0)) begin
                o_fwdSel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard controller: tracks the E/M/W writers in a shift
// scoreboard and derives the F/D stall plus D- and E-stage forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W = SB_REG_W,
    parameter int T_W   = SB_T_W
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [T_W-1:0]   t_use_rs_d,
    input  logic [T_W-1:0]   t_use_rt_d,
    input  logic [T_W-1:0]   t_new_d,
    input  logic [REG_W-1:0] a3_d,
    input  logic             we_d,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e
);

    sb_entry_t        r_sbE;
    sb_entry_t        r_sbM;
    sb_entry_t        r_sbW;
    logic [REG_W-1:0] r_rsE;
    logic [REG_W-1:0] r_rtE;
    logic [T_W-1:0]   r_tUseRsE;
    logic [T_W-1:0]   r_tUseRtE;

    logic             w_stallRs;
    logic             w_stallRt;
    logic             w_unusedStallRsE;
    logic             w_unusedStallRtE;
    sb_entry_t        w_entEMasked;

    assign w_entEMasked = '0;
    assign stall        = w_stallRs | w_stallRt;

    // On a stall the decoder holds D, so E takes a bubble while M and W drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sbE     <= '0;
            r_sbM     <= '0;
            r_sbW     <= '0;
            r_rsE     <= '0;
            r_rtE     <= '0;
            r_tUseRsE <= '0;
            r_tUseRtE <= '0;
        end else begin
            r_sbW <= '{valid: r_sbM.valid, a3: r_sbM.a3, tnew: tnewDec(r_sbM.tnew)};
            r_sbM <= '{valid: r_sbE.valid, a3: r_sbE.a3, tnew: tnewDec(r_sbE.tnew)};
            if (stall) begin
                r_sbE     <= '0;
                r_rsE     <= '0;
                r_rtE     <= '0;
                r_tUseRsE <= '0;
                r_tUseRtE <= '0;
            end else begin
                r_sbE     <= '{valid: we_d, a3: a3_d, tnew: t_new_d};
                r_rsE     <= rs_d;
                r_rtE     <= rt_d;
                r_tUseRsE <= t_use_rs_d;
                r_tUseRtE <= t_use_rt_d;
            end
        end
    end

    hazard_operand_check u_checkRsD (
        .i_idx      (rs_d),
        .i_tUse     (t_use_rs_d),
        .i_entE     (r_sbE),
        .i_entM     (r_sbM),
        .i_entW     (r_sbW),
        .o_stallReq (w_stallRs),
        .o_fwdSel   (fwd_rs_d)
    );

    hazard_operand_check u_checkRtD (
        .i_idx      (rt_d),
        .i_tUse     (t_use_rt_d),
        .i_entE     (r_sbE),
        .i_entM     (r_sbM),
        .i_entW     (r_sbW),
        .o_stallReq (w_stallRt),
        .o_fwdSel   (fwd_rt_d)
    );

    // E operands only look older than themselves, so the E slot is blanked.
    hazard_operand_check u_checkRsE (
        .i_idx      (r_rsE),
        .i_tUse     (r_tUseRsE),
        .i_entE     (w_entEMasked),
        .i_entM     (r_sbM),
        .i_entW     (r_sbW),
        .o_stallReq (w_unusedStallRsE),
        .o_fwdSel   (fwd_rs_e)
    );

    hazard_operand_check u_checkRtE (
        .i_idx      (r_rtE),
        .i_tUse     (r_tUseRtE),
        .i_entE     (w_entEMasked),
        .i_entM     (r_sbM),
        .i_entW     (r_sbW),
        .o_stallReq (w_unusedStallRtE),
        .o_fwdSel   (fwd_rt_e)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table of
// instruction streams plus hand-written reset sequences.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] t_use_rs_d;
    logic [1:0] t_use_rt_d;
    logic [1:0] t_new_d;
    logic [4:0] a3_d;
    logic       we_d;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuRs;
        logic [1:0] tuRt;
        logic [1:0] tnew;
        logic [4:0] a3;
        logic       we;
        logic       expStall;
        logic [1:0] expRsD;
        logic [1:0] expRtD;
        logic [1:0] expRsE;
        logic [1:0] expRtE;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard #(.REG_W(5), .T_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .t_use_rs_d (t_use_rs_d),
        .t_use_rt_d (t_use_rt_d),
        .t_new_d    (t_new_d),
        .a3_d       (a3_d),
        .we_d       (we_d),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] tuRs, input logic [1:0] tuRt,
                          input logic [1:0] tnew, input logic [4:0] a3, input logic we,
                          input logic eStall, input logic [1:0] eRsD, input logic [1:0] eRtD,
                          input logic [1:0] eRsE, input logic [1:0] eRtE);
        vec_t v;
        v.rs = rs; v.rt = rt; v.tuRs = tuRs; v.tuRt = tuRt;
        v.tnew = tnew; v.a3 = a3; v.we = we;
        v.expStall = eStall; v.expRsD = eRsD; v.expRtD = eRtD;
        v.expRsE = eRsE; v.expRtE = eRtE;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rs_d = v.rs; rt_d = v.rt; t_use_rs_d = v.tuRs; t_use_rt_d = v.tuRt;
        t_new_d = v.tnew; a3_d = v.a3; we_d = v.we;
    endtask

    task automatic checkOutput(input string tag, input logic eStall, input logic [1:0] eRsD,
                               input logic [1:0] eRtD, input logic [1:0] eRsE,
                               input logic [1:0] eRtE);
        compare({tag, " stall"},    {1'b0, stall}, {1'b0, eStall});
        compare({tag, " fwd_rs_d"}, fwd_rs_d, eRsD);
        compare({tag, " fwd_rt_d"}, fwd_rt_d, eRtD);
        compare({tag, " fwd_rs_e"}, fwd_rs_e, eRsE);
        compare({tag, " fwd_rt_e"}, fwd_rt_e, eRtE);
    endtask

    task automatic driveNop();
        rs_d = '0; rt_d = '0; t_use_rs_d = '0; t_use_rt_d = '0;
        t_new_d = '0; a3_d = '0; we_d = 1'b0;
    endtask

    initial begin
        //        rs  rt tuRs tuRt tnew a3 we | stall rsD rtD rsE rtE
        // lw $1 ; add $2,$1,$3 (t_use 1)
        addVec(0,  0, 0, 0, T_NEW_LOAD, 1, 1,  0, 0, 0, 0, 0);
        addVec(1,  3, 1, 1, T_NEW_ALU,  2, 1,  1, 0, 0, 0, 0);
        addVec(1,  3, 1, 1, T_NEW_ALU,  2, 1,  0, 0, 0, 0, 0);
        addVec(0,  0, 0, 0, 0,          0, 0,  0, 0, 0, 3, 0);
        // add $1 ; beq $1,$2 (t_use 0), $2 still in W from the previous add
        addVec(0,  0, 0, 0, T_NEW_ALU,  1, 1,  0, 0, 0, 0, 0);
        addVec(1,  2, 0, 0, 0,          0, 0,  1, 0, 3, 0, 0);
        addVec(1,  2, 0, 0, 0,          0, 0,  0, 2, 0, 0, 0);
        addVec(0,  0, 0, 0, 0,          0, 0,  0, 0, 0, 3, 0);
        // lw $1 ; beq $1,$0 -> two stall cycles
        addVec(0,  0, 0, 0, T_NEW_LOAD, 1, 1,  0, 0, 0, 0, 0);
        addVec(1,  0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0);
        addVec(1,  0, 0, 0, 0,          0, 0,  1, 0, 0, 0, 0);
        addVec(1,  0, 0, 0, 0,          0, 0,  0, 3, 0, 0, 0);
        addVec(0,  0, 0, 0, 0,          0, 0,  0, 0, 0, 0, 0);
        // addi $1 ; lw $1 ; add $4,$1,$1 -> nearer writer shadows older ones
        addVec(0,  0, 0, 0, T_NEW_ALU,  1, 1,  0, 0, 0, 0, 0);
        addVec(0,  0, 0, 0, T_NEW_LOAD, 1, 1,  0, 0, 0, 0, 0);
        addVec(1,  1, 1, 1, T_NEW_ALU,  4, 1,  1, 0, 0, 0, 0);
        addVec(1,  1, 1, 1, T_NEW_ALU,  4, 1,  0, 0, 0, 0, 0);
        addVec(0,  0, 0, 0, 0,          0, 0,  0, 0, 0, 3, 3);
        // add $0 ; use $0 and $4
        addVec(0,  0, 0, 0, T_NEW_ALU,  0, 1,  0, 0, 0, 0, 0);
        addVec(0,  4, 0, 0, 0,          0, 0,  0, 0, 3, 0, 0);
        // jal ; jr $31
        addVec(0,  0, 0, 0, T_NEW_LINK, 31, 1, 0, 0, 0, 0, 0);
        addVec(31, 0, 0, 0, 0,          0, 0,  0, 1, 0, 0, 0);
        addVec(0,  0, 0, 0, 0,          0, 0,  0, 0, 0, 2, 0);

        driveNop();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 checkOutput("reset_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1 checkOutput($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expRsD,
                           vecs[i].expRtD, vecs[i].expRsE, vecs[i].expRtE);
        end

        // Reset arriving while a load-use stall is active.
        @(negedge clk);
        driveNop();
        a3_d = 5'd1; we_d = 1'b1; t_new_d = T_NEW_LOAD;
        @(negedge clk);
        driveNop();
        rs_d = 5'd1;
        #1 checkOutput("pre_reset", 1, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 checkOutput("reset_mid_stall", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("after_release", 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 checkOutput("after_release_clk", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Sequential hazard controller for the five-stage pipeline. It sits directly downstream of the instruction decoder and consumes the decoder's D-stage outputs each cycle: register indices, T_use and T_new, and the write target. It keeps a shift-register scoreboard of the instructions in E, M and W. From that scoreboard it drives the stall for F/D and the forwarding selects for the D- and E-stage operand muxes.

## Interface
Parameters:
- REG_W, 5, register index width
- T_W, 2, width of T_use/T_new fields

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs_d  in  REG_W  D-stage rs index from decoder
- rt_d  in  REG_W  D-stage rt index from decoder
- t_use_rs_d  in  T_W  cycles until rs is needed, counted from D
- t_use_rt_d  in  T_W  cycles until rt is needed, counted from D
- t_new_d  in  T_W  cycles after entering E until the result exists (ALU 1, load 2, link 0)
- a3_d  in  REG_W  destination register; 0 = no write
- we_d  in  1  D instruction writes GRF
- stall  out  1  freeze PC and F/D, insert bubble into E
- fwd_rs_d, fwd_rt_d  out  2  D operand source: 0 GRF, 1 E, 2 M, 3 W
- fwd_rs_e, fwd_rt_e  out  2  E operand source: 0 pipe reg, 2 M, 3 W (1 unused)

## Operation
- Scoreboard has three entries, E, M and W. Each entry holds valid, a3 and tnew. Entry E additionally holds rs, rt, t_use_rs and t_use_rt.
- An entry is a writer iff valid and a3 != 0.
- Each posedge, with no stall: D fields move to E. For the E entry, tnew = t_new_d and valid = we_d. E moves to M and M moves to W, each with tnew = max(tnew-1, 0).
- Each posedge, with stall: E is loaded with a bubble (valid=0). E to M and M to W still advance. D inputs are held upstream.
- Stall rule is evaluated per operand; stall = OR of both operands. For operand rs_d (rt_d identically):
  - Skip the operand if its index is 0.
  - Stall if E is a writer with a3==rs_d and tnew_E > t_use_rs_d.
  - Else stall if M is a writer with a3==rs_d and tnew_M > t_use_rs_d. The M check is reached only when E does not match.
- D forwarding uses the nearest matching writer in priority order E, then M, then W:
  - Select that stage only if its tnew is 0; otherwise select 0.
  - A nearer match with tnew > 0 shadows older stages. The select is then 0, and that case is always covered by a stall or by later E-stage forwarding.
- E forwarding uses the E entry's stored rs/rt against M, then W, nearest first, with the same tnew==0 rule. Index 0 always gives select 0.
- All outputs are combinational from the scoreboard and the D inputs. Only the scoreboard is registered.

## Timing
- Reset (reset_n low, async): all entries are invalid, tnew=0 and a3=0. With all entries empty, stall=0 and every fwd select is 0 immediately, with no clock required.
- Reset release takes effect at the first posedge with reset_n high.
- Reset asserted mid-stall: stall drops the same cycle. Any in-flight writers are discarded.
- Stall latency is 0 cycles: stall is asserted in the same cycle the hazardous instruction sits in D.
- The maximum stall is 2 consecutive cycles (load, then a consumer with T_use 0).
- tnew saturates at 0 and never wraps.
- A W entry always has tnew 0.
- An entry with a3==0 never matches, even when valid.

## Structure
- Shared package hazard_pkg holds:
  - FWD_NONE=0, FWD_E=1, FWD_M=2, FWD_W=3
  - the sb_entry_t struct {valid, a3, tnew}
  - the T_NEW_ALU=1, T_NEW_LOAD=2 and T_NEW_LINK=0 constants, shared with the decoder
- One sub-module is natural: hazard_operand_check. It is combinational: one operand index, its t_use and the three entries in; stall_req and fwd_sel out.
  - It is instantiated twice for D (rs, rt).
  - Its forward path is reused twice for E (rs, rt), with the E entry masked.

## Test plan
- Reset: drive reset_n=0 with the scoreboard loaded by prior traffic -> stall=0 and all fwd=0 within the same cycle. They stay 0 after release until new writers enter.
- lw $1 then add $2,$1,$3 (t_use_rs=1):
  - cycle 1 -> stall=1.
  - next cycle -> stall=0 and fwd_rs_d=0.
  - one cycle later, with add in E -> fwd_rs_e=3.
- add $1 then beq $1 (t_use_rs=0, t_new=1):
  - cycle 1 -> stall=1.
  - next cycle -> stall=0, fwd_rs_d=2.
- lw $1 then beq $1,$0 (t_use=0) -> stall=1 for exactly 2 cycles, then fwd_rs_d=3.
- Shadowing:
  - addi $1 then lw $1 then add $4,$1,$1 -> E (lw) shadows M: stall=1. The old M value is never selected.
  - add $0,... then use $0 -> no stall and all fwd=0.
- jal (a3=31, t_new=0) then jr $31 (t_use=0) -> no stall, fwd_rs_d=1.
